mult_error_monitor: RTL and testbench

- Downstream characterisation stage for the 8x8 approximate multipliers.
- Takes operand pairs plus the approximate product the multiplier produced for them, computes the exact product internally, and accumulates error statistics over a run of N_SAMPLES accepted samples.
- Final statistics are read out when done is high.

---
 rtl/mult_error_monitor.sv | 221 ++++++++++++++++++++++
 tb/tb_mult_error_monitor.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_error_monitor.sv
// mult_error_monitor
// Characterisation stage for 8x8 approximate multipliers. Each accepted
// sample (op_a, op_b, approx_y) is compared against the exact product and
// folded into run statistics: error count, saturating sum of error
// distances, maximum error distance and the operands that first produced it.
// Two-stage pipeline: stage 1 registers the sample and its exact product,
// stage 2 forms the error distance and updates the statistics.
//
// Optional feature macro: ERRMON_BIAS_EN
//   defined   -> bias_sum accumulates signed (approx_y - exact), wrapping
//   undefined -> no bias logic, bias_sum tied to 0
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | after reset, waiting for start
// S_RUN   | accepting samples until N_SAMPLES have been taken
// S_DRAIN | two cycles for the last sample to pass through the pipeline
// S_DONE  | statistics final and stable, waiting for start

`timescale 1ns/1ps

module mult_error_monitor #(
    parameter int N_SAMPLES = 65536,
    parameter int ACC_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       op_a,
    input  logic [7:0]       op_b,
    input  logic [15:0]      approx_y,
    output logic             busy,
    output logic             done,
    output logic [16:0]      err_count,
    output logic [ACC_W-1:0] sum_ed,
    output logic [15:0]      max_ed,
    output logic [7:0]       max_a,
    output logic [7:0]       max_b,
    output logic [ACC_W-1:0] bias_sum
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [16:0] LAST_IDX = 17'(N_SAMPLES - 1);

    state_t           state_q;
    logic [16:0]      cnt_q;
    logic             drain_q;
    logic             in_ready_q;
    logic             busy_q;
    logic             done_q;

    logic             s1_valid_q;
    logic [7:0]       s1_a_q;
    logic [7:0]       s1_b_q;
    logic [15:0]      s1_y_q;
    logic [15:0]      s1_exact_q;

    logic [16:0]      err_count_q;
    logic [ACC_W-1:0] sum_ed_q;
    logic [15:0]      max_ed_q;
    logic [7:0]       max_a_q;
    logic [7:0]       max_b_q;

    logic             accept;
    logic             clear;
    logic [15:0]      ed;
    logic [ACC_W:0]   sum_ext;

    assign accept = in_valid && in_ready_q;
    assign clear  = start && ((state_q == S_IDLE) || (state_q == S_DONE));

    // Run sequencing, sample counter and registered handshake/status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            drain_q    <= 1'b0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q    <= S_RUN;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        cnt_q <= cnt_q + 17'd1;
                        if (cnt_q == LAST_IDX) begin
                            state_q    <= S_DRAIN;
                            drain_q    <= 1'b0;
                            in_ready_q <= 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_q) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        drain_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                end
            endcase
        end
    end

    // Stage 1: capture the accepted sample and its exact product
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_y_q     <= '0;
            s1_exact_q <= '0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_a_q     <= op_a;
                s1_b_q     <= op_b;
                s1_y_q     <= approx_y;
                s1_exact_q <= {8'd0, op_a} * {8'd0, op_b};
            end
        end
    end

    // Stage 2 arithmetic: error distance and widened sum for saturation detect
    always_comb begin
        ed = '0;
        if (s1_exact_q >= s1_y_q) begin
            ed = s1_exact_q - s1_y_q;
        end else begin
            ed = s1_y_q - s1_exact_q;
        end
        sum_ext = {1'b0, sum_ed_q} + {{(ACC_W-15){1'b0}}, ed};
    end

    // Stage 2 statistics; max only moves on a strictly larger distance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count_q <= '0;
            sum_ed_q    <= '0;
            max_ed_q    <= '0;
            max_a_q     <= '0;
            max_b_q     <= '0;
        end else if (clear) begin
            err_count_q <= '0;
            sum_ed_q    <= '0;
            max_ed_q    <= '0;
            max_a_q     <= '0;
            max_b_q     <= '0;
        end else if (s1_valid_q) begin
            if (ed != 16'd0) begin
                err_count_q <= err_count_q + 17'd1;
            end
            if (sum_ext[ACC_W]) begin
                sum_ed_q <= '1;
            end else begin
                sum_ed_q <= sum_ext[ACC_W-1:0];
            end
            if (ed > max_ed_q) begin
                max_ed_q <= ed;
                max_a_q  <= s1_a_q;
                max_b_q  <= s1_b_q;
            end
        end
    end

`ifdef ERRMON_BIAS_EN
    logic [16:0]      bias_diff;
    logic [ACC_W-1:0] bias_sum_q;

    assign bias_diff = {1'b0, s1_y_q} - {1'b0, s1_exact_q};

    // Signed bias accumulator, two's complement wrap-around
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bias_sum_q <= '0;
        end else if (clear) begin
            bias_sum_q <= '0;
        end else if (s1_valid_q) begin
            bias_sum_q <= bias_sum_q + ACC_W'($signed(bias_diff));
        end
    end

    assign bias_sum = bias_sum_q;
`else
    assign bias_sum = '0;
`endif

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err_count = err_count_q;
    assign sum_ed    = sum_ed_q;
    assign max_ed    = max_ed_q;
    assign max_a     = max_a_q;
    assign max_b     = max_b_q;

endmodule

// File: tb/tb_mult_error_monitor.sv
// Directed testbench for mult_error_monitor. Four instances share the input
// stream: index 0 N=4, 1 N=2, 2 N=3 (all ACC_W=32), 3 N=4 with ACC_W=17.

`timescale 1ns/1ps

module tb_mult_error_monitor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic [15:0] approx_y;

    logic        rdy [4];
    logic        bsy [4];
    logic        dn  [4];
    logic [16:0] ec  [4];
    logic [15:0] med [4];
    logic [7:0]  ma  [4];
    logic [7:0]  mb  [4];
    logic [31:0] sum32  [3];
    logic [31:0] bias32 [3];
    logic [16:0] sum17;
    logic [16:0] bias17;

    int checks = 0;
    int errors = 0;

    mult_error_monitor #(.N_SAMPLES(4), .ACC_W(32)) u_n4 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(rdy[0]),
        .op_a(op_a), .op_b(op_b), .approx_y(approx_y), .busy(bsy[0]), .done(dn[0]),
        .err_count(ec[0]), .sum_ed(sum32[0]), .max_ed(med[0]), .max_a(ma[0]),
        .max_b(mb[0]), .bias_sum(bias32[0]));

    mult_error_monitor #(.N_SAMPLES(2), .ACC_W(32)) u_n2 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(rdy[1]),
        .op_a(op_a), .op_b(op_b), .approx_y(approx_y), .busy(bsy[1]), .done(dn[1]),
        .err_count(ec[1]), .sum_ed(sum32[1]), .max_ed(med[1]), .max_a(ma[1]),
        .max_b(mb[1]), .bias_sum(bias32[1]));

    mult_error_monitor #(.N_SAMPLES(3), .ACC_W(32)) u_n3 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(rdy[2]),
        .op_a(op_a), .op_b(op_b), .approx_y(approx_y), .busy(bsy[2]), .done(dn[2]),
        .err_count(ec[2]), .sum_ed(sum32[2]), .max_ed(med[2]), .max_a(ma[2]),
        .max_b(mb[2]), .bias_sum(bias32[2]));

    mult_error_monitor #(.N_SAMPLES(4), .ACC_W(17)) u_sat (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(rdy[3]),
        .op_a(op_a), .op_b(op_b), .approx_y(approx_y), .busy(bsy[3]), .done(dn[3]),
        .err_count(ec[3]), .sum_ed(sum17), .max_ed(med[3]), .max_a(ma[3]),
        .max_b(mb[3]), .bias_sum(bias17));

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [15:0] y);
        in_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        approx_y = y;
        step();
        in_valid = 1'b0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic do_start;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int k);
        int n;
        n = 0;
        while (dn[k] !== 1'b1 && n < 30) begin
            step();
            n++;
        end
        check($sformatf("wait_done[%0d]", k), {63'd0, dn[k]}, 64'd1);
    endtask

    initial begin
        int pat [6];
        pat = '{1, 0, 0, 1, 0, 1};

        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        op_a     = '0;
        op_b     = '0;
        approx_y = '0;
        step();
        check("rst_err_count", ec[0], 0);
        check("rst_sum_ed", sum32[0], 0);
        check("rst_max_ed", med[0], 0);
        check("rst_max_a", ma[0], 0);
        check("rst_max_b", mb[0], 0);
        check("rst_bias_sum", bias32[0], 0);
        check("rst_in_ready", rdy[0], 0);
        check("rst_busy", bsy[0], 0);
        check("rst_done", dn[0], 0);
        rst = 1'b0;
        step();

        // exact samples: no error statistics at all
        do_start();
        check("t1_in_ready_run", rdy[0], 1);
        check("t1_busy_run", bsy[0], 1);
        send(8'd1, 8'd1, 16'd1);
        send(8'd2, 8'd3, 16'd6);
        send(8'd0, 8'd9, 16'd0);
        send(8'd255, 8'd255, 16'd65025);
        wait_done(0);
        check("t1_err_count", ec[0], 0);
        check("t1_sum_ed", sum32[0], 0);
        check("t1_max_ed", med[0], 0);
        check("t1_max_a", ma[0], 0);
        check("t1_max_b", mb[0], 0);
        check("t1_in_ready_done", rdy[0], 0);

        // two erroneous samples, N=2
        do_reset();
        do_start();
        send(8'd3, 8'd5, 16'd14);
        send(8'd4, 8'd4, 16'd20);
        wait_done(1);
        check("t2_err_count", ec[1], 2);
        check("t2_sum_ed", sum32[1], 5);
        check("t2_max_ed", med[1], 4);
        check("t2_max_a", ma[1], 4);
        check("t2_max_b", mb[1], 4);
`ifdef ERRMON_BIAS_EN
        check("t2_bias_sum", bias32[1], 3);
`else
        check("t2_bias_sum", bias32[1], 0);
`endif

        // ties keep first occurrence
        do_reset();
        do_start();
        send(8'd255, 8'd255, 16'd64000);
        send(8'd10, 8'd10, 16'd99);
        send(8'd255, 8'd255, 16'd64000);
        send(8'd205, 8'd5, 16'd0);
        wait_done(2);
        check("t3_max_ed", med[2], 1025);
        check("t3_max_a", ma[2], 255);
        check("t3_max_b", mb[2], 255);
        check("t3_sum_ed", sum32[2], 2051);
        check("t3_err_count", ec[2], 3);
        wait_done(0);
        check("t3_n4_err_count", ec[0], 4);
        check("t3_n4_sum_ed", sum32[0], 3076);
        check("t3_n4_max_ed", med[0], 1025);
        check("t3_n4_max_a", ma[0], 255);
        check("t3_n4_max_b", mb[0], 255);

        // saturation with ACC_W=17
        do_reset();
        do_start();
        repeat (4) send(8'd255, 8'd255, 16'd0);
        wait_done(3);
        check("t4_sat_sum_ed", sum17, 131071);
        check("t4_sat_err_count", ec[3], 4);
        check("t4_sat_max_ed", med[3], 65025);
        check("t4_wide_sum_ed", sum32[0], 260100);

        // gaps in in_valid, start pulse ignored in RUN
        do_reset();
        do_start();
        for (int i = 0; i < 6; i++) begin
            in_valid = (pat[i] == 1);
            op_a     = (pat[i] == 1) ? 8'd1 : 8'd2;
            op_b     = (pat[i] == 1) ? 8'd1 : 8'd2;
            approx_y = 16'd0;
            start    = (i == 1);
            check($sformatf("t5_in_ready_run[%0d]", i), rdy[2], 1);
            step();
        end
        in_valid = 1'b0;
        start    = 1'b0;
        check("t5_drain_in_ready", rdy[2], 0);
        check("t5_drain_busy", bsy[2], 1);
        check("t5_drain_done0", dn[2], 0);
        step();
        check("t5_drain_done1", dn[2], 0);
        step();
        check("t5_done_at_2", dn[2], 1);
        check("t5_done_in_ready", rdy[2], 0);
        check("t5_done_busy", bsy[2], 0);
        check("t5_err_count", ec[2], 3);
        check("t5_sum_ed", sum32[2], 3);
        step();
        check("t5_done_hold", dn[2], 1);

        // asynchronous reset mid-run, then a clean run
        do_reset();
        do_start();
        send(8'd3, 8'd5, 16'd14);
        send(8'd4, 8'd4, 16'd20);
        step();
        check("t6_partial_err_count", ec[0], 2);
        rst = 1'b1;
        #1;
        check("t6_rst_err_count", ec[0], 0);
        check("t6_rst_sum_ed", sum32[0], 0);
        check("t6_rst_max_ed", med[0], 0);
        check("t6_rst_max_a", ma[0], 0);
        check("t6_rst_in_ready", rdy[0], 0);
        check("t6_rst_busy", bsy[0], 0);
        check("t6_rst_done", dn[0], 0);
        step();
        rst = 1'b0;
        step();
        do_start();
        send(8'd2, 8'd2, 16'd3);
        send(8'd6, 8'd7, 16'd40);
        send(8'd1, 8'd1, 16'd1);
        send(8'd0, 8'd5, 16'd0);
        wait_done(0);
        check("t6_err_count", ec[0], 2);
        check("t6_sum_ed", sum32[0], 3);
        check("t6_max_ed", med[0], 2);
        check("t6_max_a", ma[0], 6);
        check("t6_max_b", mb[0], 7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
